// File: rtl/vending_machine_n.sv
// vending_machine_n -- parametrised vending controller.
// Collects coins for a selected product, dispenses with change, and refunds
// on cancel or after TIMEOUT_CYC idle cycles while collecting.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   BTN[N_PROD]       : product select buttons (level)
//   cancel            : cancel request (level)
//   Money_in[3]       : one-hot coin (001=1, 010=2, 100=5 units)
//   product[N_PROD]   : one-hot dispense strobe
//   delivered         : dispense strobe, any product
//   refunded          : refund strobe (cancel or timeout)
//   LED[N_PROD]       : selected-product indicator
//   credit            : current inserted credit
//   change            : returned amount, qualified by change_valid
//   change_valid      : change strobe
//   coin_reject       : coin event ignored or invalid
module vending_machine_n #(
  parameter int                         N_PROD      = 3,
  parameter int                         PRICE_W     = 8,
  parameter logic [N_PROD*PRICE_W-1:0]  PRICES      = {8'd5, 8'd3, 8'd2},
  parameter int                         TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PROD-1:0]  BTN,
  input  logic               cancel,
  input  logic [2:0]         Money_in,
  output logic [N_PROD-1:0]  product,
  output logic               delivered,
  output logic               refunded,
  output logic [N_PROD-1:0]  LED,
  output logic [PRICE_W-1:0] credit,
  output logic [PRICE_W-1:0] change,
  output logic               change_valid,
  output logic               coin_reject
);

  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [CNT_W-1:0]   cnt;
  logic [N_PROD-1:0]  btn_p1;
  logic               cancel_p1;
  logic [2:0]         coin_p1;

  logic [N_PROD-1:0]  btn_ev;
  logic               btn_any;
  logic [SEL_W-1:0]   btn_idx;
  logic               cancel_ev;
  logic               coin_ev;
  logic               coin_ok;
  logic               coin_add;
  logic [PRICE_W-1:0] price_sel;
  logic [PRICE_W-1:0] sum;

  function automatic logic [PRICE_W-1:0] coin_value(input logic [2:0] m);
    case (m)
      3'b001:  coin_value = PRICE_W'(1);
      3'b010:  coin_value = PRICE_W'(2);
      3'b100:  coin_value = PRICE_W'(5);
      default: coin_value = '0;
    endcase
  endfunction

  function automatic logic [PRICE_W-1:0] price_of(input logic [SEL_W-1:0] s);
    price_of = PRICES[int'(s)*PRICE_W +: PRICE_W];
  endfunction

  function automatic logic [N_PROD-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    sel_onehot    = '0;
    sel_onehot[s] = 1'b1;
  endfunction

  // Stage p0: edge detection against the previous-cycle samples
  assign btn_ev    = BTN & ~btn_p1;
  assign btn_any   = |btn_ev;
  assign cancel_ev = cancel & ~cancel_p1;
  assign coin_ev   = (Money_in != 3'b000) && (coin_p1 == 3'b000);
  assign coin_ok   = $onehot(Money_in);
  assign coin_add  = coin_ev && coin_ok;
  assign price_sel = price_of(sel);
  // Credit including this edge's coin; bounded by max price + 4, so no wrap.
  assign sum       = coin_add ? (credit + coin_value(Money_in)) : credit;

  // Lowest index wins when several buttons rise together.
  always_comb begin
    btn_idx = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (btn_ev[i]) btn_idx = SEL_W'(i);
    end
  end

  // Stage p1: state, credit and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= '0;
      cnt          <= '0;
      credit       <= '0;
      btn_p1       <= '0;
      cancel_p1    <= 1'b0;
      coin_p1      <= 3'b000;
      product      <= '0;
      delivered    <= 1'b0;
      refunded     <= 1'b0;
      LED          <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      btn_p1       <= BTN;
      cancel_p1    <= cancel;
      coin_p1      <= Money_in;
      product      <= '0;
      delivered    <= 1'b0;
      refunded     <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;

      case (state)
        IDLE: begin
          LED <= '0;
          if (coin_ev) coin_reject <= 1'b1;
          if (btn_any) begin
            sel   <= btn_idx;
            cnt   <= '0;
            LED   <= sel_onehot(btn_idx);
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (coin_ev && !coin_ok) coin_reject <= 1'b1;
          if (coin_add) begin
            credit <= sum;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // Cancel outranks payment; timeout only applies without a coin,
          // and then sum equals credit.
          if (cancel_ev || (!coin_add && sum < price_sel &&
                            cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            refunded     <= 1'b1;
            change       <= sum;
            change_valid <= (sum != '0);
            LED          <= '0;
            state        <= REFUND;
          end else if (sum >= price_sel) begin
            product      <= sel_onehot(sel);
            delivered    <= 1'b1;
            change       <= sum - price_sel;
            change_valid <= (sum != price_sel);
            state        <= DISPENSE;
          end
        end

        default: begin
          if (coin_ev) coin_reject <= 1'b1;
          credit <= '0;
          LED    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vending_machine_n.md
Name: vending_machine_n

Overview:
- Parametrised successor of the three-product vending controller.
- Supports N_PROD products with per-product prices set by parameter.
- Adds cancel/refund, an inactivity timeout with refund, change computation and a binary credit readout.
- Sits between the debounced button/coin inputs and the dispense, LED and display logic. The 7-segment driver consumes `credit` externally.

Parameters:
- N_PROD, 3, number of products/buttons (1..8)
- PRICE_W, 8, width of prices, credit and change
- PRICES, {8'd5,8'd3,8'd2}, packed price table; product i price = PRICES[i*PRICE_W +: PRICE_W]; every price must be <= 2^PRICE_W-6
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before automatic refund (>=2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- BTN  in  N_PROD  product select buttons, level, debounced externally
- cancel  in  1  cancel request, level
- Money_in  in  3  coin input, one-hot: 001=1, 010=2, 100=5 units
- product  out  N_PROD  one-hot dispense strobe
- delivered  out  1  dispense strobe, any product
- refunded  out  1  refund strobe (cancel or timeout)
- LED  out  N_PROD  selected-product indicator
- credit  out  PRICE_W  current inserted credit
- change  out  PRICE_W  amount returned, valid with change_valid
- change_valid  out  1  change strobe
- coin_reject  out  1  strobe: coin event ignored or invalid

Behaviour:
- One clock, synchronous active-high reset. Reset is sampled on the clk rising edge and has priority over all other inputs.
- Reset values: state=IDLE, credit=0, selection=0, timeout counter=0, registered copies of BTN/cancel/Money_in=0, all outputs 0.
- Reset mid-operation discards credit. No refund is issued.
- Edge detection on the registered previous sample:
  - Button event: BTN[i]=1 and previous BTN[i]=0.
  - Cancel event: rising edge of cancel.
  - Coin event: Money_in!=0 and previous Money_in==0.
- A coin event with Money_in not one-hot (2+ bits set) adds nothing and pulses coin_reject for 1 cycle.
- Multiple buttons rising on the same edge: lowest index wins.
- States:
  - IDLE:
    - Button event on i: latch sel=i, go to COLLECT.
    - Valid coin: credit unchanged, coin_reject=1 for 1 cycle.
    - Cancel is ignored.
  - COLLECT:
    - Valid coin: credit <= credit+value, timeout counter cleared.
    - If credit+value >= PRICE(sel), go to DISPENSE on the same edge.
    - If PRICE(sel)==0, go to DISPENSE on the first COLLECT edge with no coin needed.
    - Cancel event, or timeout counter reaching TIMEOUT_CYC-1 with no coin: go to REFUND.
    - Further button events are ignored.
  - DISPENSE (exactly 1 cycle):
    - product[sel]=1 and delivered=1.
    - change=credit-PRICE(sel).
    - change_valid=1 only if change!=0.
    - Next edge: credit<=0, go to IDLE.
  - REFUND (exactly 1 cycle):
    - refunded=1, change=credit.
    - change_valid=1 only if credit!=0.
    - Next edge: credit<=0, go to IDLE.
- Outputs are Moore-decoded from registers.
  - LED[sel]=1 in COLLECT and DISPENSE, else 0.
  - credit is always driven from the register.
  - change=0 outside DISPENSE/REFUND.
- Latency:
  - Coin sampled at edge k: credit visible after k.
  - If the coin completes payment, delivered is high during the cycle after edge k.
- Simultaneous events in COLLECT:
  - Cancel and valid coin on the same edge: coin added, then REFUND with the full sum.
  - Coin and timeout expiry on the same edge: coin wins, counter cleared.
  - Cancel and payment completion on the same edge: cancel wins, everything refunded, no dispense.
- Width: credit never exceeds max price+4, so no overflow.
- Timeout counter width is $clog2(TIMEOUT_CYC).
- Coins/buttons held high produce one event only. Release (return to 0) is required before the next event.

Test Plan:
- Reset with all outputs checked, then BTN[0] edge, coin 1, release, coin 1 -> LED[0]=1 in COLLECT; credit 1 then 2; product=001, delivered=1 for exactly 1 cycle; change_valid=0; then IDLE with credit=0.
- BTN[1] (price 3), coin 5 -> product=010, delivered=1, change=2, change_valid=1 in the same cycle.
- BTN[2] (price 5), coin 2, then cancel and coin 1 rising on the same edge -> refunded=1, change=3, change_valid=1, no product pulse.
- BTN[2], coin 1, then no activity for TIMEOUT_CYC cycles -> refunded=1, change=1 exactly TIMEOUT_CYC cycles after the coin edge. Also check that a coin at cycle TIMEOUT_CYC-1 instead restarts the count.
- In IDLE: Money_in=011 -> coin_reject=1, credit=0. BTN[0] and BTN[2] rising together -> sel=0, LED=001. In COLLECT, Money_in=110 -> coin_reject, credit unchanged.
- BTN[2], coin 2, then reset asserted for 1 cycle -> next cycle all outputs 0, credit=0, no refund or change strobe.
